// File: rtl/rob_window.sv
// Reorder buffer: circular array between dispatch and retire with an N-wide head window
// (lane N-1 = oldest), CDB completion, self-popping retire and mispredict flush.

package rob_window_pkg;
  parameter int unsigned RobN  = 3;
  parameter int unsigned RobSz = 8;
  parameter int unsigned AddrW = 32;

  typedef logic [$clog2(RobSz)-1:0] rob_idx_t;
  typedef logic [AddrW-1:0]         addr_t;

  typedef struct packed {
    addr_t      pc;
    logic [4:0] dest_reg;
    logic       is_branch;
    logic       branch_taken;
    addr_t      branch_target;
    rob_idx_t   rob_idx;
    logic       complete;
  } rob_entry_t;
endpackage

module rob_window
  import rob_window_pkg::*;
#(
  parameter int unsigned N      = RobN,
  parameter int unsigned ROB_SZ = RobSz
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic       [N-1:0]    disp_valid,
  input  rob_entry_t [N-1:0]    disp_entries,
  output logic                  disp_ready,
  output rob_idx_t   [N-1:0]    disp_rob_idx,
  output logic [$clog2(ROB_SZ+1)-1:0] free_slots,
  input  logic       [N-1:0]    cdb_valid,
  input  rob_idx_t   [N-1:0]    cdb_rob_idx,
  input  logic       [N-1:0]    cdb_branch_taken,
  input  addr_t      [N-1:0]    cdb_branch_target,
  input  logic                  rob_mispredict,
  input  rob_idx_t              rob_mispred_idx,
  output rob_entry_t [N-1:0]    head_entries,
  output logic       [N-1:0]    head_valids
);

  localparam int unsigned IW = $clog2(ROB_SZ);
  localparam int unsigned CW = $clog2(ROB_SZ + 1);
  localparam int unsigned LW = $clog2(N + 1);

  rob_entry_t          entries_q [ROB_SZ];
  logic [ROB_SZ-1:0]   valid_q, valid_d;
  logic [IW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;

  logic [LW-1:0]       disp_cnt, pop_cnt;
  logic [N-1:0]        disp_mask;
  logic                disp_fire;
  logic                walking;
  rob_entry_t [N-1:0]  disp_rec;
  logic [IW-1:0]       head_ptr [N];

  always_comb begin
    disp_cnt = '0;
    for (int k = 0; k < N; k++) disp_cnt = disp_cnt + LW'(disp_valid[k]);
    // Legal dispatch groups are the top disp_cnt lanes.
    disp_mask = ~({N{1'b1}} >> disp_cnt);
  end

  // Capacity is judged on registered occupancy; same-cycle pops are not credited.
  assign free_slots = CW'(ROB_SZ) - count_q;
  assign disp_ready = CW'(disp_cnt) <= free_slots;
  assign disp_fire  = disp_ready && (disp_cnt != '0) && !rob_mispredict;

  always_comb begin
    for (int j = 0; j < N; j++) begin
      disp_rob_idx[N-1-j]         = rob_idx_t'(tail_q + IW'(j));
      disp_rec[N-1-j]             = disp_entries[N-1-j];
      disp_rec[N-1-j].rob_idx     = rob_idx_t'(tail_q + IW'(j));
      disp_rec[N-1-j].complete    = 1'b0;
    end
  end

  // Head window plus the retire walk: pop the complete run starting at the oldest lane.
  always_comb begin
    pop_cnt = '0;
    walking = 1'b1;
    for (int k = N - 1; k >= 0; k--) begin
      head_ptr[k]     = head_q + IW'(N - 1 - k);
      head_entries[k] = entries_q[head_ptr[k]];
      head_valids[k]  = CW'(N - 1 - k) < count_q;
      if (walking && head_valids[k] && head_entries[k].complete) begin
        pop_cnt = pop_cnt + LW'(1);
      end else begin
        walking = 1'b0;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rob_mispredict) begin
      valid_d = '0;
      count_d = '0;
      head_d  = IW'(rob_mispred_idx) + IW'(1);
      tail_d  = IW'(rob_mispred_idx) + IW'(1);
    end else begin
      for (int j = 0; j < N; j++) begin
        if (LW'(j) < pop_cnt) valid_d[head_q + IW'(j)] = 1'b0;
      end
      if (disp_fire) begin
        for (int j = 0; j < N; j++) begin
          if (disp_valid[N-1-j]) valid_d[tail_q + IW'(j)] = 1'b1;
        end
        tail_d = tail_q + IW'(disp_cnt);
      end
      head_d  = head_q + IW'(pop_cnt);
      count_d = count_q + (disp_fire ? CW'(disp_cnt) : '0) - CW'(pop_cnt);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: it is only observed through valid bits.
  always_ff @(posedge clock) begin
    if (!rob_mispredict) begin
      if (disp_fire) begin
        for (int j = 0; j < N; j++) begin
          if (disp_valid[N-1-j]) entries_q[tail_q + IW'(j)] <= disp_rec[N-1-j];
        end
      end
      for (int l = 0; l < N; l++) begin
        if (cdb_valid[l] && valid_q[cdb_rob_idx[l]]) begin
          entries_q[cdb_rob_idx[l]].complete      <= 1'b1;
          entries_q[cdb_rob_idx[l]].branch_taken  <= cdb_branch_taken[l];
          entries_q[cdb_rob_idx[l]].branch_target <= cdb_branch_target[l];
        end
      end
    end
  end

  assert property (@(posedge clock) disable iff (!reset) disp_valid == disp_mask)
    else $error("rob_window: disp_valid is not a contiguous run from lane N-1");

  assert property (@(posedge clock) disable iff (!reset) rob_mispredict |-> head_valids[N-1])
    else $error("rob_window: mispredict with empty head");

  for (genvar l = 0; l < N; l++) begin : g_cdb_chk
    assert property (@(posedge clock) disable iff (!reset)
                     cdb_valid[l] |-> valid_q[cdb_rob_idx[l]])
      else $warning("rob_window: cdb lane %0d targets an invalid entry", l);
  end

endmodule

// File: tb/tb_rob_window.sv
// Directed table-driven bench for rob_window (N=3, ROB_SZ=8) plus reset and CDB payload sequences.

module tb_rob_window;
  import rob_window_pkg::*;

  logic               clock = 1'b0;
  logic               reset;
  logic       [2:0]   disp_valid;
  rob_entry_t [2:0]   disp_entries;
  logic               disp_ready;
  rob_idx_t   [2:0]   disp_rob_idx;
  logic       [3:0]   free_slots;
  logic       [2:0]   cdb_valid;
  rob_idx_t   [2:0]   cdb_rob_idx;
  logic       [2:0]   cdb_branch_taken;
  addr_t      [2:0]   cdb_branch_target;
  logic               rob_mispredict;
  rob_idx_t           rob_mispred_idx;
  rob_entry_t [2:0]   head_entries;
  logic       [2:0]   head_valids;

  rob_window #(.N(3), .ROB_SZ(8)) dut (
    .clock             (clock),
    .reset             (reset),
    .disp_valid        (disp_valid),
    .disp_entries      (disp_entries),
    .disp_ready        (disp_ready),
    .disp_rob_idx      (disp_rob_idx),
    .free_slots        (free_slots),
    .cdb_valid         (cdb_valid),
    .cdb_rob_idx       (cdb_rob_idx),
    .cdb_branch_taken  (cdb_branch_taken),
    .cdb_branch_target (cdb_branch_target),
    .rob_mispredict    (rob_mispredict),
    .rob_mispred_idx   (rob_mispred_idx),
    .head_entries      (head_entries),
    .head_valids       (head_valids)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] dv;
    logic [2:0] cv;
    logic [8:0] cidx;    // {lane2, lane1, lane0}
    logic       mis;
    logic [2:0] mis_idx;
    logic       e_rdy;
    logic [3:0] e_free;
    logic [2:0] e_hv;
    logic [2:0] e_tail;
    logic [8:0] e_hidx;  // masked by e_hv
    logic [2:0] e_comp;  // masked by e_hv
  } vec_t;

  localparam int NumVec = 25;
  vec_t vecs [NumVec];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t v(input logic [2:0] dv, input logic [2:0] cv, input logic [8:0] cidx,
                             input logic mis, input logic [2:0] mis_idx, input logic e_rdy,
                             input logic [3:0] e_free, input logic [2:0] e_hv,
                             input logic [2:0] e_tail, input logic [8:0] e_hidx,
                             input logic [2:0] e_comp);
    vec_t r;
    r.dv = dv; r.cv = cv; r.cidx = cidx; r.mis = mis; r.mis_idx = mis_idx;
    r.e_rdy = e_rdy; r.e_free = e_free; r.e_hv = e_hv; r.e_tail = e_tail;
    r.e_hidx = e_hidx; r.e_comp = e_comp;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_entries(input int tag);
    for (int k = 0; k < 3; k++) begin
      disp_entries[k]          = '0;
      disp_entries[k].pc       = 32'h4000_0000 | (32'(tag) << 4) | 32'(k);
      disp_entries[k].dest_reg = 5'(k + 1);
      disp_entries[k].rob_idx  = '1;   // must be overwritten by the ROB
      disp_entries[k].complete = 1'b1; // must be forced to 0 by the ROB
    end
  endtask

  task automatic idle_inputs();
    disp_valid        = '0;
    cdb_valid         = '0;
    cdb_rob_idx       = '0;
    cdb_branch_taken  = '0;
    cdb_branch_target = '0;
    rob_mispredict    = 1'b0;
    rob_mispred_idx   = '0;
  endtask

  logic [8:0] hmask;

  initial begin
    //           dv      cv      cidx    mis idx rdy free hv      tail hidx    comp
    vecs[0]  = v(3'b111, 3'b000, 9'o000, 0, 0, 1, 8, 3'b000, 0, 9'o000, 3'b000);
    vecs[1]  = v(3'b000, 3'b101, 9'o002, 0, 0, 1, 5, 3'b111, 3, 9'o012, 3'b000);
    vecs[2]  = v(3'b000, 3'b000, 9'o000, 0, 0, 1, 5, 3'b111, 3, 9'o012, 3'b101);
    vecs[3]  = v(3'b000, 3'b100, 9'o100, 0, 0, 1, 6, 3'b110, 3, 9'o120, 3'b010);
    vecs[4]  = v(3'b000, 3'b000, 9'o000, 0, 0, 1, 6, 3'b110, 3, 9'o120, 3'b110);
    vecs[5]  = v(3'b000, 3'b000, 9'o000, 0, 0, 1, 8, 3'b000, 3, 9'o000, 3'b000);
    vecs[6]  = v(3'b111, 3'b000, 9'o000, 0, 0, 1, 8, 3'b000, 3, 9'o000, 3'b000);
    vecs[7]  = v(3'b111, 3'b000, 9'o000, 0, 0, 1, 5, 3'b111, 6, 9'o345, 3'b000);
    vecs[8]  = v(3'b111, 3'b000, 9'o000, 0, 0, 0, 2, 3'b111, 1, 9'o345, 3'b000);
    vecs[9]  = v(3'b110, 3'b000, 9'o000, 0, 0, 1, 2, 3'b111, 1, 9'o345, 3'b000);
    vecs[10] = v(3'b100, 3'b000, 9'o000, 0, 0, 0, 0, 3'b111, 3, 9'o345, 3'b000);
    vecs[11] = v(3'b000, 3'b111, 9'o345, 0, 0, 1, 0, 3'b111, 3, 9'o345, 3'b000);
    vecs[12] = v(3'b000, 3'b111, 9'o670, 0, 0, 1, 0, 3'b111, 3, 9'o345, 3'b111);
    vecs[13] = v(3'b000, 3'b000, 9'o000, 0, 0, 1, 3, 3'b111, 3, 9'o670, 3'b111);
    vecs[14] = v(3'b000, 3'b000, 9'o000, 0, 0, 1, 6, 3'b110, 3, 9'o120, 3'b000);
    vecs[15] = v(3'b111, 3'b000, 9'o000, 0, 0, 1, 6, 3'b110, 3, 9'o120, 3'b000);
    vecs[16] = v(3'b110, 3'b111, 9'o123, 0, 0, 1, 3, 3'b111, 6, 9'o123, 3'b000);
    vecs[17] = v(3'b110, 3'b000, 9'o000, 0, 0, 0, 1, 3'b111, 0, 9'o123, 3'b111);
    vecs[18] = v(3'b110, 3'b000, 9'o000, 0, 0, 1, 4, 3'b111, 0, 9'o456, 3'b000);
    vecs[19] = v(3'b000, 3'b100, 9'o400, 0, 0, 1, 2, 3'b111, 2, 9'o456, 3'b000);
    vecs[20] = v(3'b000, 3'b000, 9'o000, 0, 0, 1, 2, 3'b111, 2, 9'o456, 3'b100);
    vecs[21] = v(3'b110, 3'b100, 9'o600, 1, 5, 1, 3, 3'b111, 2, 9'o567, 3'b000);
    vecs[22] = v(3'b000, 3'b000, 9'o000, 0, 0, 1, 8, 3'b000, 6, 9'o000, 3'b000);
    vecs[23] = v(3'b111, 3'b000, 9'o000, 0, 0, 1, 8, 3'b000, 6, 9'o000, 3'b000);
    vecs[24] = v(3'b000, 3'b000, 9'o000, 0, 0, 1, 5, 3'b111, 1, 9'o670, 3'b000);

    reset = 1'b0;
    idle_inputs();
    drive_entries(0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock); #1;
    chk("reset head_valids", 64'(head_valids), 64'(3'b000));
    chk("reset free_slots", 64'(free_slots), 64'd8);
    chk("reset disp_ready", 64'(disp_ready), 64'd1);

    // Reset in the middle of operation, asserted between clock edges.
    disp_valid = 3'b111;
    @(negedge clock);
    disp_valid = '0;
    #1;
    chk("pre-reset free_slots", 64'(free_slots), 64'd5);
    chk("pre-reset head_valids", 64'(head_valids), 64'(3'b111));
    #2 reset = 1'b0;
    #1;
    chk("async reset head_valids", 64'(head_valids), 64'(3'b000));
    chk("async reset free_slots", 64'(free_slots), 64'd8);
    @(negedge clock);
    reset = 1'b1;
    disp_valid = 3'b111;
    #1;
    chk("post-reset disp_rob_idx", 64'(disp_rob_idx), 64'(9'o012));
    chk("post-reset disp_ready", 64'(disp_ready), 64'd1);
    disp_valid = '0;

    for (int i = 0; i < NumVec; i++) begin
      @(negedge clock);
      disp_valid      = vecs[i].dv;
      drive_entries(i);
      cdb_valid       = vecs[i].cv;
      cdb_rob_idx[2]  = vecs[i].cidx[8:6];
      cdb_rob_idx[1]  = vecs[i].cidx[5:3];
      cdb_rob_idx[0]  = vecs[i].cidx[2:0];
      rob_mispredict  = vecs[i].mis;
      rob_mispred_idx = vecs[i].mis_idx;
      #1;
      hmask = {{3{vecs[i].e_hv[2]}}, {3{vecs[i].e_hv[1]}}, {3{vecs[i].e_hv[0]}}};
      chk($sformatf("v%0d disp_ready", i), 64'(disp_ready), 64'(vecs[i].e_rdy));
      chk($sformatf("v%0d free_slots", i), 64'(free_slots), 64'(vecs[i].e_free));
      chk($sformatf("v%0d head_valids", i), 64'(head_valids), 64'(vecs[i].e_hv));
      chk($sformatf("v%0d disp_rob_idx", i), 64'(disp_rob_idx),
          64'({vecs[i].e_tail, 3'(vecs[i].e_tail + 3'd1), 3'(vecs[i].e_tail + 3'd2)}));
      chk($sformatf("v%0d head rob_idx", i),
          64'({head_entries[2].rob_idx, head_entries[1].rob_idx, head_entries[0].rob_idx} & hmask),
          64'(vecs[i].e_hidx));
      chk($sformatf("v%0d head complete", i),
          64'({head_entries[2].complete, head_entries[1].complete, head_entries[0].complete}
              & vecs[i].e_hv),
          64'(vecs[i].e_comp));
    end

    // CDB payload: head is entries 6,7,0 dispatched in vector 23.
    @(negedge clock);
    idle_inputs();
    cdb_valid            = 3'b110;
    cdb_rob_idx[2]       = 3'd6;
    cdb_rob_idx[1]       = 3'd7;
    cdb_branch_taken     = 3'b100;
    cdb_branch_target[2] = 32'hDEAD_BEE0;
    cdb_branch_target[1] = 32'h0000_1234;
    #1;
    chk("cdb same-cycle complete", 64'({head_entries[2].complete, head_entries[1].complete}),
        64'(2'b00));
    @(negedge clock);
    idle_inputs();
    #1;
    chk("cdb lane2 complete", 64'(head_entries[2].complete), 64'd1);
    chk("cdb lane2 taken", 64'(head_entries[2].branch_taken), 64'd1);
    chk("cdb lane2 target", 64'(head_entries[2].branch_target), 64'h0000_0000_DEAD_BEE0);
    chk("cdb lane1 taken", 64'(head_entries[1].branch_taken), 64'd0);
    chk("cdb lane1 target", 64'(head_entries[1].branch_target), 64'h0000_1234);
    chk("lane0 payload pc", 64'(head_entries[0].pc), 64'h4000_0170);
    chk("lane0 complete", 64'(head_entries[0].complete), 64'd0);
    chk("lane0 dest_reg", 64'(head_entries[0].dest_reg), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
